// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button press classifier:
//   - btn_state_t  : 3-bit state encoding of the classifier FSM
//   - ms_to_cycles : converts a millisecond duration into clock cycles
//   - sat_inc      : 32-bit saturating increment used by the cycle counter
// ---------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESSED     = 3'd1,
        ST_WAIT_GAP    = 3'd2,
        ST_SECOND_HELD = 3'd3,
        ST_LONG_HELD   = 3'd4
    } btn_state_t;

    // Whole cycles per millisecond times the duration; the result is
    // truncated to the 32-bit width of the cycle counter.
    function automatic logic [31:0] ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return 32'((clk_freq / 1000) * ms);
    endfunction

    // The counter sticks at all-ones rather than wrapping back to zero, so a
    // very long hold can never re-trigger a threshold.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/btn_press_classifier.sv
// ---------------------------------------------------------------------------
// btn_press_classifier
// Classifies a debounced, synchronised button level into short, long and
// double presses, with an optional auto-repeat while a long press is held.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   defined   -> repeat_pulse fires every REPEAT_COUNT cycles in LONG_HELD
//   undefined -> repeat_pulse is constant 0 and no repeat logic exists
//
// Parameters:
//   CLK_FREQ       system clock frequency in Hz
//   LONG_PRESS_MS  minimum hold time for a long press
//   DOUBLE_GAP_MS  maximum release-to-repress gap for a double press
//   REPEAT_MS      auto-repeat period (only with BTN_AUTO_REPEAT_EN)
//
// Ports:
//   clk           system clock (single domain)
//   rst           synchronous active-high reset
//   btn_in        debounced, synchronised button level
//   short_press   one-cycle pulse for a single short press
//   long_press    one-cycle pulse when the hold reaches LONG_COUNT
//   double_press  one-cycle pulse on the second press of a double press
//   repeat_pulse  one-cycle auto-repeat pulse
//   held          high while in PRESSED, LONG_HELD or SECOND_HELD
// ---------------------------------------------------------------------------
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned LONG_PRESS_MS = 800,
    parameter int unsigned DOUBLE_GAP_MS = 250,
    parameter int unsigned REPEAT_MS     = 150
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [31:0] LONG_COUNT = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
    localparam logic [31:0] GAP_COUNT  = ms_to_cycles(CLK_FREQ, DOUBLE_GAP_MS);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [31:0] REPEAT_COUNT = ms_to_cycles(CLK_FREQ, REPEAT_MS);
`endif

    btn_state_t  state;
    logic [31:0] cnt;
    logic        btn_q;
    logic        rise;
    logic        fall;

    // Edge detection against the one-cycle-delayed level. btn_q resets to 0,
    // so a button already down when reset releases still produces a rise.
    assign rise = btn_in & ~btn_q;
    assign fall = ~btn_in & btn_q;

    // held is a pure decode of the state register, so it is glitch-free and
    // changes on the same edge as the state.
    assign held = (state == ST_PRESSED) ||
                  (state == ST_LONG_HELD) ||
                  (state == ST_SECOND_HELD);

    // Main classifier FSM. Pulse outputs default low every cycle and are set
    // only on the edge that takes the qualifying decision, which makes each
    // one exactly one cycle wide. The counter runs freely and is zeroed on
    // every state change; in PRESSED a fall wins over the long threshold and
    // in WAIT_GAP a rise wins over gap expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 32'd0;
            btn_q        <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            repeat_pulse <= 1'b0;
`endif
        end else begin
            btn_q        <= btn_in;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            repeat_pulse <= 1'b0;
`endif
            cnt          <= sat_inc(cnt);

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_PRESSED;
                        cnt   <= 32'd0;
                    end
                end

                ST_PRESSED: begin
                    if (fall) begin
                        state <= ST_WAIT_GAP;
                        cnt   <= 32'd0;
                    end else if (cnt == LONG_COUNT - 32'd1) begin
                        long_press <= 1'b1;
                        state      <= ST_LONG_HELD;
                        cnt        <= 32'd0;
                    end
                end

                ST_WAIT_GAP: begin
                    if (rise) begin
                        double_press <= 1'b1;
                        state        <= ST_SECOND_HELD;
                        cnt          <= 32'd0;
                    end else if (cnt == GAP_COUNT - 32'd1) begin
                        short_press <= 1'b1;
                        state       <= ST_IDLE;
                        cnt         <= 32'd0;
                    end
                end

                ST_SECOND_HELD: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= 32'd0;
                    end
                end

                ST_LONG_HELD: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= 32'd0;
`ifdef BTN_AUTO_REPEAT_EN
                    end else if (cnt == REPEAT_COUNT - 32'd1) begin
                        // Same state, but the period restarts from zero.
                        repeat_pulse <= 1'b1;
                        cnt          <= 32'd0;
`endif
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= 32'd0;
                end
            endcase
        end
    end

`ifndef BTN_AUTO_REPEAT_EN
    // Repeat feature compiled out: the output is constant 0. REPEAT_MS is
    // still referenced so both builds accept the same parameter set.
    assign repeat_pulse = 1'b0 & (REPEAT_MS != 0);
`endif

endmodule
